wishbone_cmd_master: RTL and testbench

Single-outstanding Wishbone classic master that sits directly upstream of the team's register-file Wishbone slave.
- Accepts read/write commands from a controller over a valid/ready interface and buffers them in a small command FIFO.
- Issues each command as one cyc/stb bus cycle.
- Returns write acknowledgements and read data over a valid/ready response interface.
- Bus-side port names and widths match the slave, so the two connect one-to-one.

---
 rtl/wishbone_cmd_master.sv | 218 +++++++++++++++++++++
 tb/tb_wishbone_cmd_master.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_cmd_master.sv
// wishbone_cmd_master: single-outstanding Wishbone classic master.
// Commands arrive on a valid/ready port, queue in a small FIFO, and each one
// runs as a single cyc/stb cycle. Its response goes back on a valid/ready port.
// Optional build macro: WB_MASTER_TIMEOUT_EN. When defined, a bus cycle that
// gets no ack within TIMEOUT_CYCLES is aborted and reported with rsp_err=1.
// When undefined, the master waits for ack indefinitely and rsp_err stays 0.
module wishbone_cmd_master #(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] adr,
  output logic [DATA_W-1:0] dat_mosi,
  input  logic [DATA_W-1:0] dat_miso,
  output logic              we,
  output logic              cyc,
  output logic              stb,
  input  logic              ack,
  output logic              busy
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

  // Reject configurations that would break pointer wrap or the abort logic.
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
      (TIMEOUT_CYCLES < 2)) begin : g_bad_params
    $error("wishbone_cmd_master: FIFO_DEPTH must be a power of 2 >= 2, TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  // Command FIFO
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push, pop;
  logic               head_we;
  logic [ADDR_W-1:0]  head_adr;
  logic [DATA_W-1:0]  head_wdata;

  // FSM and registered outputs
  state_t             state_q, state_d;
  logic               cyc_q, cyc_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  adr_q, adr_d;
  logic [DATA_W-1:0]  dat_q, dat_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_we_q, rsp_we_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               rsp_err_q, rsp_err_d;
`endif

  // Ready depends only on the registered count, never on req_valid.
  assign req_ready = (count_q != CNT_W'(FIFO_DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = (state_q == S_IDLE) && (count_q != '0);
  assign {head_we, head_adr, head_wdata} = fifo_mem[rd_ptr_q];

  // FIFO storage write; no reset needed since occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {req_we, req_adr, req_wdata};
    end
  end

  // FIFO occupancy: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and count; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Next-state and output logic; every register holds unless a state acts.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_we_d    = rsp_we_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef WB_MASTER_TIMEOUT_EN
    tmo_d       = tmo_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          we_d    = head_we;
          adr_d   = head_adr;
          dat_d   = head_wdata;
          cyc_d   = 1'b1;
          state_d = S_BUS;
`ifdef WB_MASTER_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      S_BUS: begin
        // ack takes priority over an expiry in the same cycle.
        if (ack) begin
          rsp_rdata_d = we_q ? '0 : dat_miso;
          rsp_we_d    = we_q;
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
`ifdef WB_MASTER_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
        end
`ifdef WB_MASTER_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_rdata_d = '0;
          rsp_we_d    = we_q;
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = S_RESP;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops the bus cycle and any response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
      tmo_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef WB_MASTER_TIMEOUT_EN
      tmo_q       <= tmo_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign cyc       = cyc_q;
  assign stb       = cyc_q;
  assign we        = we_q;
  assign adr       = adr_q;
  assign dat_mosi  = dat_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_rdata = rsp_rdata_q;
`ifdef WB_MASTER_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif
  assign busy      = (count_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_wishbone_cmd_master.sv
// Testbench for wishbone_cmd_master: directed stimulus with a response
// scoreboard, a registered-ack slave model and a bus-timing monitor.
module tb_wishbone_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [3:0]  req_adr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_we, rsp_err;
  logic [31:0] rsp_rdata;
  logic [3:0]  adr;
  logic [31:0] dat_mosi, dat_miso;
  logic        we, cyc, stb, ack, busy;

  wishbone_cmd_master #(
    .ADDR_W(4), .DATA_W(32), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .adr(adr), .dat_mosi(dat_mosi), .dat_miso(dat_miso),
    .we(we), .cyc(cyc), .stb(stb), .ack(ack), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [16];
  logic [31:0] slv_mem [16];
  int tests_run    = 0;
  int tests_failed = 0;
  int n_expected   = 0;
  int rsp_cnt      = 0;
  bit ack_en       = 1'b1;
  bit ack_stretch  = 1'b0;
  int exp_width    = 2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Slave model: registered ack (naturally one extra cycle after stb falls),
  // optionally stretched one more cycle; registered read data.
  logic ack_q, ack_dly;
  always @(posedge clk) begin
    if (!rst_n) begin
      ack_q   <= 1'b0;
      ack_dly <= 1'b0;
    end else begin
      ack_q   <= ack_en && cyc && stb;
      ack_dly <= ack_q;
    end
    if (cyc && stb && we) slv_mem[adr] <= dat_mosi;
    dat_miso <= slv_mem[adr];
  end
  assign ack = ack_q | (ack_stretch & ack_dly);

  // Monitor: stb pulse width, stb low gap, and scoreboard on each response.
  int stb_w = 0;
  int gap   = 0;
  bit have_prev = 1'b0;
  bit prev_stb  = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      have_prev = 1'b0;
      prev_stb  = 1'b0;
      stb_w     = 0;
    end else begin
      if (stb) begin
        if (!prev_stb) begin
          if (have_prev) chk("stb_gap_ge2", 32'(gap >= 2), 32'd1);
          stb_w = 0;
        end
        stb_w++;
      end else begin
        if (prev_stb) begin
          if (exp_width != 0) chk("stb_width", stb_w, exp_width);
          have_prev = 1'b1;
          gap = 0;
        end
        gap++;
      end
      prev_stb = stb;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_rsp", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("[TB] rsp %0d we=%0b rdata=0x%08h err=%0b", rsp_cnt, rsp_we, rsp_rdata, rsp_err);
          chk("rsp_we", rsp_we, e.we);
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", rsp_err, e.err);
        end
        rsp_cnt++;
      end
    end
  end

  // Drive one command, wait (bounded) for acceptance, record its expectation.
  task automatic push(input logic w, input logic [3:0] a, input logic [31:0] d, input logic e_err);
    exp_t e;
    int n;
    req_we = w; req_adr = a; req_wdata = d; req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) begin
      chk("accept_timeout", req_ready, 1'b1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.we    = w;
    e.err   = e_err;
    e.rdata = (w || e_err) ? 32'd0 : model_mem[a];
    if (w && !e_err) model_mem[a] = d;
    exp_q.push_back(e);
    n_expected++;
    $display("[TB] req we=%0b adr=%0d wdata=0x%08h", w, a, d);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int c;
    int base;
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = 32'd0;
      slv_mem[i]   = 32'd0;
    end
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_cyc", cyc, 1'b0);
    chk("rst_stb", stb, 1'b0);
    chk("rst_we", we, 1'b0);
    chk("rst_adr", 32'(adr), 32'd0);
    chk("rst_dat_mosi", dat_mosi, 32'd0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_we", rsp_we, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write then read back
    push(1'b1, 4'd3, 32'hDEADBEEF, 1'b0);
    push(1'b0, 4'd3, 32'h0, 1'b0);
    drain("drain_wr_rd");

    // Latency from accept edge to rsp_valid, then back-to-back reads
    push(1'b0, 4'd3, 32'h1234, 1'b0);
    c = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      c = i;
      if (rsp_valid) break;
    end
    chk("latency", c, 3);
    drain("drain_latency");
    push(1'b0, 4'd3, 32'h0, 1'b0);
    push(1'b0, 4'd0, 32'h0, 1'b0);
    drain("drain_b2b");

    // FIFO full / backpressure
    for (int i = 0; i < 5; i++) push(1'b1, 4'(i), 32'h100 + i, 1'b0);
    drain("drain_preload");
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(1'b0, 4'(i), 32'h0, 1'b0);
    req_we = 1'b0; req_adr = 4'd5; req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("full_req_ready", req_ready, 1'b0);
    end
    chk("full_busy", busy, 1'b1);
    chk("full_no_rsp_yet", 32'(exp_q.size()), 32'd5);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain("drain_full");

    // Stale ack rejection with a stretched slave ack
    ack_stretch = 1'b1;
    base = rsp_cnt;
    push(1'b1, 4'd7, 32'h55AA55AA, 1'b0);
    push(1'b0, 4'd7, 32'h0, 1'b0);
    push(1'b0, 4'd3, 32'h0, 1'b0);
    drain("drain_stale");
    repeat (4) @(posedge clk);
    #1;
    chk("stale_rsp_count", rsp_cnt - base, 3);
    ack_stretch = 1'b0;

    // Reset in the middle of a bus cycle
    exp_width = 0;
    ack_en = 1'b0;
    push(1'b0, 4'd1, 32'h0, 1'b0);
    c = 0;
    while (!stb && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    chk("midbus_stb_seen", stb, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_cyc", cyc, 1'b0);
    chk("midrst_stb", stb, 1'b0);
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    chk("midrst_req_ready", req_ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    exp_q.delete();
    n_expected--;
    rst_n = 1'b1;
    ack_en = 1'b1;
    @(posedge clk); #1;
    exp_width = 2;
    push(1'b0, 4'd3, 32'h0, 1'b0);
    drain("drain_after_rst");

`ifdef WB_MASTER_TIMEOUT_EN
    // Timeout abort, then a normal command
    exp_width = 8;
    ack_en = 1'b0;
    push(1'b0, 4'd2, 32'h0, 1'b1);
    drain("drain_timeout");
    ack_en = 1'b1;
    exp_width = 2;
    push(1'b0, 4'd3, 32'h0, 1'b0);
    drain("drain_post_timeout");
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rsp_total", rsp_cnt, n_expected);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
